nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit ripple-carry adder reused once per clock, LSB nibble first.
// Optional subtract mode with NSA_SUB_EN defined (adds the sub port; A - B via inverted B and carry-in 1).
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
`ifdef NSA_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Cout
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q, s_q;
  logic          carry_q, cout_q;
  logic [IW-1:0] idx_q;
`ifdef NSA_SUB_EN
  logic          sub_q;
`endif

  // the single shared RCA4
  logic [3:0] rca_a, rca_b, rca_s;
  logic [4:0] rca_c;
  logic [W-1:0] sum_ext;

  always_comb begin
    rca_a = a_q[3:0];
`ifdef NSA_SUB_EN
    rca_b = b_q[3:0] ^ {4{sub_q}};
`else
    rca_b = b_q[3:0];
`endif
    rca_c    = '0;
    rca_s    = '0;
    rca_c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      rca_s[i]   = rca_a[i] ^ rca_b[i] ^ rca_c[i];
      rca_c[i+1] = (rca_a[i] & rca_b[i]) | (rca_c[i] & (rca_a[i] ^ rca_b[i]));
    end
  end

  assign sum_ext = W'(rca_s);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef NSA_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q   <= A;
          b_q   <= B;
          idx_q <= '0;
`ifdef NSA_SUB_EN
          sub_q   <= sub;
          carry_q <= sub | Cin & ~sub;
`else
          carry_q <= Cin;
`endif
        end
        RUN: begin
          // each sum nibble enters at the top, so after NIBBLES shifts nibble 0 sits at the bottom
          s_q     <= (s_q >> 4) | (sum_ext << (W-4));
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= rca_c[4];
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST) cout_q <= rca_c[4];
        end
        default: ;
      endcase
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: transaction-level model checked every cycle plus directed literal vectors.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4*N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start, cin, busy, done, cout, sub;
  logic [W-1:0] a, b, s;
  logic         start1, cin1, busy1, done1, cout1, sub1;
  logic [3:0]   a1, b1, s1;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin),
`ifdef NSA_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .S(s), .Cout(cout));

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
`ifdef NSA_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: cnt = cycles since accept (0 = idle); result computed with plain arithmetic at accept
  int           cnt = 0;
  logic [W:0]   full = '0;
  logic [W-1:0] exp_s = '0;
  logic         exp_c = 1'b0;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    logic msub;
    msub = 1'b0;
`ifdef NSA_SUB_EN
    msub = sub;
`endif
    if (rst) begin
      cnt = 0; exp_s = '0; exp_c = 1'b0;
    end else if (cnt == 0) begin
      if (start) begin
        if (msub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else      full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        cnt = 1;
      end
    end else if (cnt < N) begin
      cnt++;
    end else if (cnt == N) begin
      cnt   = N + 1;
      exp_s = full[W-1:0];
      exp_c = full[W];
    end else begin
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", busy, (cnt >= 1 && cnt <= N));
      chk("model_done", done, (cnt == N + 1));
      chk("busy_done_excl", busy & done, 0);
      if (!(cnt >= 1 && cnt <= N)) begin
        chk("model_S", s, exp_s);
        chk("model_Cout", cout, exp_c);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic vsub, input logic [W-1:0] es, input logic ec);
    int k, nb;
    a = va; b = vb; cin = vc; sub = vsub; start = 1'b1;
    k = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (busy) nb++;
      if (done) break;
    end
    chk("op_latency", k, N + 1);
    chk("op_busy_cycles", nb, N);
    chk("op_S", s, es);
    chk("op_Cout", cout, ec);
    @(negedge clk);
  endtask

  initial begin
    int seen, last, cyc, ndone, k;
    start = 0; a = '0; b = '0; cin = 0; sub = 0;
    start1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", s, 0);
    chk("rst_Cout", cout, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1);
`ifdef NSA_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`endif

    // start held high; operands scrambled while busy must not leak into the result
    start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    last = -1; ndone = 0;
    for (cyc = 0; cyc < 26; cyc++) begin
      @(negedge clk);
      if (busy) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
      else begin a = 16'h00FF; b = 16'h0001; cin = 1'b0; end
      if (done) begin
        ndone++;
        chk("held_S", s, 16'h0100);
        chk("held_Cout", cout, 0);
        if (last >= 0) chk("held_period", cyc - last, 6);
        last = cyc;
      end
    end
    chk("held_ops", ndone, 4);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // reset in the 2nd RUN cycle aborts without a done pulse
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_S", s, 0);
    chk("abort_Cout", cout, 0);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0);

    // single-nibble instance
    a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1; start1 = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      k++;
      if (done1) break;
    end
    chk("n1_latency", k, 2);
    chk("n1_S", s1, 4'h2);
    chk("n1_Cout", cout1, 1);
    @(negedge clk);
    chk("n1_idle_done", done1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
